// File: rtl/ara_cluster_dispatcher.sv
// Fans CVA6 accelerator requests out to NrClusters Ara macros and joins their
// responses and load/store completion pulses back into a single CVA6-facing stream.
module ara_cluster_dispatcher #(
    parameter int unsigned NrClusters     = 4,
    parameter int unsigned ReqWidth       = 128,
    parameter int unsigned ResultWidth    = 64,
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned CplCntWidth    = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic [ReqWidth-1:0]               req_data_i,
    output logic                              resp_valid_o,
    input  logic                              resp_ready_i,
    output logic [ResultWidth-1:0]            resp_result_o,
    output logic                              resp_error_o,
    output logic [4:0]                        resp_fflags_o,
    output logic                              load_complete_o,
    output logic                              store_complete_o,
    output logic                              store_pending_o,
    output logic [NrClusters-1:0]             cl_req_valid_o,
    input  logic [NrClusters-1:0]             cl_req_ready_i,
    output logic [ReqWidth-1:0]               cl_req_data_o,
    input  logic [NrClusters-1:0]             cl_resp_valid_i,
    output logic [NrClusters-1:0]             cl_resp_ready_o,
    input  logic [NrClusters*ResultWidth-1:0] cl_resp_result_i,
    input  logic [NrClusters-1:0]             cl_resp_error_i,
    input  logic [NrClusters*5-1:0]           cl_resp_fflags_i,
    input  logic [NrClusters-1:0]             cl_load_complete_i,
    input  logic [NrClusters-1:0]             cl_store_complete_i,
    input  logic [NrClusters-1:0]             cl_store_pending_i
);

    localparam int unsigned            OutW    = $clog2(MaxOutstanding) + 1;
    localparam logic [OutW-1:0]        OutMax  = OutW'(MaxOutstanding);
    localparam logic [OutW-1:0]        OutOne  = OutW'(1);
    localparam logic [CplCntWidth-1:0] CplMax  = '1;
    localparam logic [CplCntWidth-1:0] CplOne  = CplCntWidth'(1);

    logic [NrClusters-1:0] sent_q, sent_d;
    logic [OutW-1:0]       outstanding_q;
    logic                  can_issue, req_accept, resp_fire;

    // Request fork: each cluster sees the request exactly once.
    assign can_issue      = outstanding_q < OutMax;
    assign cl_req_valid_o = {NrClusters{req_valid_i & can_issue}} & ~sent_q;
    assign req_ready_o    = can_issue & (&(sent_q | cl_req_ready_i));
    assign req_accept     = req_valid_i & req_ready_o;
    assign cl_req_data_o  = req_data_i;

    always_comb begin
        sent_d = sent_q | (cl_req_valid_o & cl_req_ready_i);
        if (req_accept) begin
            sent_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sent_q <= '0;
        end else begin
            sent_q <= sent_d;
        end
    end

    // Response join: one holding slot per cluster; only cluster 0 supplies the result.
    logic [NrClusters-1:0]      hv_q, err_q;
    logic [NrClusters-1:0][4:0] ff_q;
    logic [ResultWidth-1:0]     res0_q;
    logic [4:0]                 fflags_merged;

    assign cl_resp_ready_o = ~hv_q;
    assign resp_valid_o    = &hv_q;
    assign resp_fire       = resp_valid_o & resp_ready_i;
    assign resp_result_o   = res0_q;
    assign resp_error_o    = |err_q;
    assign resp_fflags_o   = fflags_merged;

    always_comb begin
        fflags_merged = '0;
        for (int i = 0; i < NrClusters; i++) begin
            fflags_merged = fflags_merged | ff_q[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hv_q   <= '0;
            err_q  <= '0;
            ff_q   <= '0;
            res0_q <= '0;
        end else if (resp_fire) begin
            hv_q <= '0;
        end else begin
            for (int i = 0; i < NrClusters; i++) begin
                if (cl_resp_valid_i[i] && !hv_q[i]) begin
                    hv_q[i]  <= 1'b1;
                    err_q[i] <= cl_resp_error_i[i];
                    ff_q[i]  <= cl_resp_fflags_i[i*5 +: 5];
                end
            end
            if (cl_resp_valid_i[0] && !hv_q[0]) begin
                res0_q <= cl_resp_result_i[ResultWidth-1:0];
            end
        end
    end

    if (NrClusters > 1) begin : g_unused
        logic unused_results;
        assign unused_results = ^cl_resp_result_i[NrClusters*ResultWidth-1:ResultWidth];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
        end else begin
            case ({req_accept, resp_fire})
                2'b10:   outstanding_q <= outstanding_q + OutOne;
                2'b01:   if (outstanding_q != '0) outstanding_q <= outstanding_q - OutOne;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    // Completion aggregation: a pulse arriving this cycle already counts toward the join.
    logic [NrClusters-1:0][CplCntWidth-1:0] ld_cnt_q, ld_cnt_d, st_cnt_q, st_cnt_d;
    logic [NrClusters-1:0]                  ld_sat, st_sat;
    logic                                   ld_fire, st_fire;

    always_comb begin
        ld_fire  = 1'b1;
        st_fire  = 1'b1;
        ld_cnt_d = ld_cnt_q;
        st_cnt_d = st_cnt_q;
        ld_sat   = '0;
        st_sat   = '0;
        for (int i = 0; i < NrClusters; i++) begin
            ld_fire = ld_fire & ((ld_cnt_q[i] != '0) | cl_load_complete_i[i]);
            st_fire = st_fire & ((st_cnt_q[i] != '0) | cl_store_complete_i[i]);
        end
        for (int i = 0; i < NrClusters; i++) begin
            if (cl_load_complete_i[i] && !ld_fire) begin
                if (ld_cnt_q[i] == CplMax) ld_sat[i] = 1'b1;
                else                       ld_cnt_d[i] = ld_cnt_q[i] + CplOne;
            end else if (!cl_load_complete_i[i] && ld_fire) begin
                ld_cnt_d[i] = ld_cnt_q[i] - CplOne;
            end
            if (cl_store_complete_i[i] && !st_fire) begin
                if (st_cnt_q[i] == CplMax) st_sat[i] = 1'b1;
                else                       st_cnt_d[i] = st_cnt_q[i] + CplOne;
            end else if (!cl_store_complete_i[i] && st_fire) begin
                st_cnt_d[i] = st_cnt_q[i] - CplOne;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ld_cnt_q         <= '0;
            st_cnt_q         <= '0;
            load_complete_o  <= 1'b0;
            store_complete_o <= 1'b0;
            store_pending_o  <= 1'b0;
        end else begin
            ld_cnt_q         <= ld_cnt_d;
            st_cnt_q         <= st_cnt_d;
            load_complete_o  <= ld_fire;
            store_complete_o <= st_fire;
            store_pending_o  <= |cl_store_pending_i;
        end
    end

    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        resp_fire |-> (outstanding_q != '0));
    a_no_saturation: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ~|{ld_sat, st_sat});

endmodule

// File: doc/ara_cluster_dispatcher.md
Name: ara_cluster_dispatcher

Overview:
- Sits between the CVA6 accelerator port and NrClusters Ara macros. It is the initiator end of each macro's request/response cut.
- Forks every accepted CVA6 request to all clusters. Joins the per-cluster responses into one merged response.
- Aggregates per-cluster load/store completion pulses into single pulses toward CVA6.
- Bounds the number of in-flight instructions.

Parameters:
- NrClusters, 4, number of Ara macros served (1..16).
- ReqWidth, 128, bit width of the request payload broadcast to clusters.
- ResultWidth, 64, width of the scalar result field.
- MaxOutstanding, 8, maximum accepted-but-unanswered requests (power of 2).
- CplCntWidth, 4, width of the per-cluster completion-pulse counters.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid from CVA6
- req_ready_o  out  1  request accepted
- req_data_i  in  ReqWidth  request payload
- resp_valid_o  out  1  merged response valid
- resp_ready_i  in  1  CVA6 accepts response
- resp_result_o  out  ResultWidth  merged result
- resp_error_o  out  1  merged exception flag
- resp_fflags_o  out  5  merged FP flags
- load_complete_o  out  1  one-cycle merged load-completion pulse
- store_complete_o  out  1  one-cycle merged store-completion pulse
- store_pending_o  out  1  OR of cluster store_pending
- cl_req_valid_o  out  NrClusters  per-cluster request valid
- cl_req_ready_i  in  NrClusters  per-cluster request ready
- cl_req_data_o  out  ReqWidth  broadcast payload, equal to req_data_i
- cl_resp_valid_i  in  NrClusters  per-cluster response valid
- cl_resp_ready_o  out  NrClusters  per-cluster response ready
- cl_resp_result_i  in  NrClusters*ResultWidth  per-cluster results
- cl_resp_error_i  in  NrClusters  per-cluster exception flags
- cl_resp_fflags_i  in  NrClusters*5  per-cluster FP flags
- cl_load_complete_i  in  NrClusters  per-cluster load-completion pulses
- cl_store_complete_i  in  NrClusters  per-cluster store-completion pulses
- cl_store_pending_i  in  NrClusters  per-cluster store_pending

Behaviour:
Reset values:
- All valid outputs, completion pulses, sent bits, response holding registers, the outstanding counter and the completion counters are 0.
- resp_result_o, resp_error_o and resp_fflags_o are 0.

Request fork:
- Holds a sent[NrClusters] register.
- can_issue = (outstanding < MaxOutstanding).
- cl_req_valid_o[i] = req_valid_i & can_issue & ~sent[i].
- req_ready_o = can_issue & all(sent[i] | cl_req_ready_i[i]). The request is accepted in the cycle the last cluster handshakes.
- On acceptance sent clears to 0. Otherwise sent[i] sets on each individual handshake.
- Combinational fork, 0-cycle latency.
- A cluster is never offered the same request twice.
- req_data_i must stay stable while req_valid_i is high; the bench checks this.

Response join:
- One holding slot per cluster: hv[i], result, error, fflags.
- cl_resp_ready_o[i] = ~hv[i]. On handshake the slot loads and hv[i] is set.
- resp_valid_o = all(hv). The output is a registered join, so the earliest response appears 1 cycle after the last cluster response arrives.
- Merge rules:
  - result = slot 0 result; all scalar results come from cluster 0.
  - error = OR of slot errors.
  - fflags = bitwise OR of slot fflags.
- On resp_valid_o & resp_ready_i all hv clear. New cluster responses are accepted from the next cycle.
- A cluster may be 1 response ahead of the others; its slot stays held until the join fires.

Outstanding counter:
- Width log2(MaxOutstanding)+1.
- +1 on request acceptance, -1 on merged response handshake, unchanged when both occur in the same cycle.
- At MaxOutstanding, req_ready_o is 0 and cl_req_valid_o is 0 for unsent clusters.
- Must never underflow; a response with count 0 raises a simulation assertion.

Completion aggregation:
- Two independent per-cluster saturating counters, one for load and one for store.
- Each counter increments on its pulse.
- When all counters of a kind are non-zero, the block emits a one-cycle pulse on the registered output next cycle and decrements every counter of that kind.
- An increment and a decrement in the same cycle leave that counter unchanged.
- Saturation at 2^CplCntWidth-1 raises an assertion.

store_pending_o: registered OR of cl_store_pending_i, 1-cycle latency.

Reset mid-operation: every state returns to its reset value asynchronously. Partially forked requests and held responses are discarded.

Test Plan:
- NrClusters=4, all cl_req_ready_i=1, single request -> all cl_req_valid_o=4'b1111 and req_ready_o=1 in the same cycle; outstanding=1.
- Clusters become ready in cycles 0,2,2,5 -> each cl_req_valid_o bit drops after its own handshake; req_ready_o=1 only in cycle 5; exactly 4 handshakes total.
- Responses arrive in cycles 3,4,7,7 with results A,B,C,D, error 0,1,0,0, fflags 01,00,10,00 -> resp_valid_o in cycle 8 with result A, error 1, fflags 5'b00011.
- 8 requests issued and no responses -> 9th request is stalled (req_ready_o=0). One merged response handshake -> the 9th request is accepted the next cycle.
- Load pulses: cluster0 twice (cycles 1,2), clusters1-3 once each (cycle 6) -> a single load_complete_o pulse in cycle 7. A second pulse appears only after clusters1-3 each pulse again.
- rst_ni asserted with sent=4'b0011 and hv=4'b0101 -> all outputs 0 immediately. After release the first request is sent to all 4 clusters.
